// File: rtl/regmst_apb.sv
`default_nettype none
// ============================================================================
// Module      : regmst_apb
// Description : APB-to-reg_native_if bridge. Converts one APB transfer into a
//               single downstream req_vld pulse, waits for ack_vld, and returns
//               the result with pready/pslverr. A watchdog turns a hung
//               downstream into an APB error followed by a soft-reset flush.
// Revision    : 1.0 - initial release
// ============================================================================
module regmst_apb #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FLUSH_CYCLES   = 4
) (
  input  logic                      regmst_apb_clk,
  input  logic                      regmst_apb_rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic                      soft_rst_req,
  output logic                      regmst_apb__downstream__req_vld,
  output logic                      regmst_apb__downstream__wr_en,
  output logic                      regmst_apb__downstream__rd_en,
  output logic [ADDR_WIDTH-1:0]     regmst_apb__downstream__addr,
  output logic [DATA_WIDTH-1:0]     regmst_apb__downstream__wr_data,
  output logic                      regmst_apb__downstream__soft_rst,
  input  logic                      downstream__regmst_apb__ack_vld,
  input  logic                      downstream__regmst_apb__err,
  input  logic [DATA_WIDTH-1:0]     downstream__regmst_apb__rd_data
);

  // Byte-offset bits that must be zero for a word-aligned access.
  localparam int c_ALIGN_BITS = $clog2(DATA_WIDTH / 8);
  // Wait counter is at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
  localparam int c_CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int c_FCNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Counter holds the number of completed WAIT cycles, so the timeout fires at
  // the end of the cycle in which it equals TIMEOUT_CYCLES-1.
  localparam logic [c_CNT_W-1:0]  c_TMO_LAST   = c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = '1;
  localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST = c_FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [c_FCNT_W-1:0]   r_fcnt, w_fcnt_nxt;
  logic                  r_flush_flag, w_flush_flag_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_req_vld, w_req_vld_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_soft_rst;
  logic                  w_unaligned;
  logic                  w_tmo;

  generate
    if (c_ALIGN_BITS > 0) begin : g_align_chk
      assign w_unaligned = |paddr[c_ALIGN_BITS-1:0];
    end else begin : g_align_none
      assign w_unaligned = 1'b0;
    end
  endgenerate

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo_en
      assign w_tmo = (r_cnt == c_TMO_LAST);
    end else begin : g_tmo_dis
      assign w_tmo = 1'b0;
    end
  endgenerate

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_fcnt_nxt       = r_fcnt;
    w_flush_flag_nxt = r_flush_flag;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_write_nxt      = r_write;
    w_req_vld_nxt    = 1'b0;
    w_wr_en_nxt      = 1'b0;
    w_rd_en_nxt      = 1'b0;
    w_prdata_nxt     = '0;
    w_pslverr_nxt    = 1'b0;
    w_pready_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (psel && penable) begin
          if (w_unaligned) begin
            // Reject locally: error response without touching downstream.
            w_state_nxt   = S_RESP;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_WAIT;
            w_addr_nxt    = ADDR_WIDTH'(paddr);
            w_wdata_nxt   = pwdata;
            w_write_nxt   = pwrite;
            w_req_vld_nxt = 1'b1;
            w_wr_en_nxt   = pwrite;
            w_rd_en_nxt   = !pwrite;
            w_cnt_nxt     = '0;
          end
        end
      end

      S_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (downstream__regmst_apb__ack_vld) begin
          w_state_nxt   = S_RESP;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = downstream__regmst_apb__err;
          w_prdata_nxt  = r_write ? '0 : downstream__regmst_apb__rd_data;
        end else if (w_tmo) begin
          w_state_nxt      = S_RESP;
          w_pready_nxt     = 1'b1;
          w_pslverr_nxt    = 1'b1;
          w_flush_flag_nxt = 1'b1;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        if (r_flush_flag) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FLUSH: begin
        // Late acks from the hung request are deliberately ignored here.
        if (r_fcnt == c_FLUSH_LAST) begin
          w_state_nxt      = S_IDLE;
          w_flush_flag_nxt = 1'b0;
        end else begin
          w_fcnt_nxt = r_fcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge regmst_apb_clk or negedge regmst_apb_rst_n) begin
    if (!regmst_apb_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_flush_flag <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_req_vld    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_prdata     <= '0;
      r_pslverr    <= 1'b0;
      r_pready     <= 1'b0;
      r_soft_rst   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_flush_flag <= w_flush_flag_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_write      <= w_write_nxt;
      r_req_vld    <= w_req_vld_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_prdata     <= w_prdata_nxt;
      r_pslverr    <= w_pslverr_nxt;
      r_pready     <= w_pready_nxt;
      // Flush pulse tracks FLUSH occupancy; the external request rides along
      // with one cycle of latency in every state.
      r_soft_rst   <= soft_rst_req | (w_state_nxt == S_FLUSH);
    end
  end

  assign prdata                           = r_prdata;
  assign pready                           = r_pready;
  assign pslverr                          = r_pslverr;
  assign regmst_apb__downstream__req_vld  = r_req_vld;
  assign regmst_apb__downstream__wr_en    = r_wr_en;
  assign regmst_apb__downstream__rd_en    = r_rd_en;
  assign regmst_apb__downstream__addr     = r_addr;
  assign regmst_apb__downstream__wr_data  = r_wdata;
  assign regmst_apb__downstream__soft_rst = r_soft_rst;

endmodule
`default_nettype wire
